// File: rtl/aes128_encrypt_if.sv
// Word-serial host bus for the AES-128 core: key/plaintext load strobes in,
// ciphertext words out under a pop strobe.
interface aes128_encrypt_if;
  logic [31:0] keyIn;
  logic [31:0] wordIn;
  logic        readFlag;
  logic        writeFlag;
  logic        done;
  logic [31:0] outBuf;

  modport master (
    output keyIn, wordIn, readFlag, writeFlag,
    input  done, outBuf
  );

  modport slave (
    input  keyIn, wordIn, readFlag, writeFlag,
    output done, outBuf
  );
endinterface

// File: rtl/aes128_encrypt.sv
// Iterative AES-128 ECB encryption core: one round per clock with the round key
// expanded alongside the data, loaded and unloaded as 32-bit words.
module aes128_encrypt (
  input  logic              Clk,
  input  logic              rst,
  aes128_encrypt_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} FsmState;

  // Forward S-box, byte 0x00 in the top eight bits.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  FsmState        fsmState, fsmNext;
  logic [2:0]     loadCnt, loadCntNext;
  logic [3:0]     roundCnt, roundNext;
  logic [1:0]     outIdx, outIdxNext;
  logic [127:0]   keyReg, keyNext;
  logic [127:0]   blockReg, blockNext;
  logic           doneReg, doneNext;
  logic [31:0]    outBufReg, outBufNext;

  logic [7:0]     rcon;
  logic [31:0]    rotSub;
  logic [31:0]    nk0, nk1, nk2, nk3;
  logic [127:0]   nextKey;
  logic [127:0]   subBytes, shifted, mixed, roundOut;
  logic [1:0]     idxInc;

  assign bus.done   = doneReg;
  assign bus.outBuf = outBufReg;

  // Round key for the round being computed, derived from the previous one.
  always_comb begin
    rcon = 8'h00;
    case (roundCnt)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    rotSub  = {sbox(keyReg[23:16]), sbox(keyReg[15:8]),
               sbox(keyReg[7:0]),   sbox(keyReg[31:24])};
    nk0     = keyReg[127:96] ^ rotSub ^ {rcon, 24'h000000};
    nk1     = keyReg[95:64] ^ nk0;
    nk2     = keyReg[63:32] ^ nk1;
    nk3     = keyReg[31:0]  ^ nk2;
    nextKey = {nk0, nk1, nk2, nk3};
  end

  always_comb begin
    subBytes = '0;
    shifted  = '0;
    mixed    = '0;
    for (int i = 0; i < 16; i++) begin
      subBytes[8*i +: 8] = sbox(blockReg[8*i +: 8]);
    end
    // Row r of column c takes the byte from column (c + r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8*(4*c + r) -: 8] = subBytes[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 32] = mixColumn(shifted[127 - 32*c -: 32]);
    end
    roundOut = ((roundCnt == 4'd10) ? shifted : mixed) ^ nextKey;
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      fsmState  <= IDLE;
      loadCnt   <= 3'd0;
      roundCnt  <= 4'd0;
      outIdx    <= 2'd0;
      keyReg    <= '0;
      blockReg  <= '0;
      doneReg   <= 1'b0;
      outBufReg <= 32'h0;
    end else begin
      fsmState  <= fsmNext;
      loadCnt   <= loadCntNext;
      roundCnt  <= roundNext;
      outIdx    <= outIdxNext;
      keyReg    <= keyNext;
      blockReg  <= blockNext;
      doneReg   <= doneNext;
      outBufReg <= outBufNext;
    end
  end

  always_comb begin
    fsmNext     = fsmState;
    loadCntNext = loadCnt;
    roundNext   = roundCnt;
    outIdxNext  = outIdx;
    keyNext     = keyReg;
    blockNext   = blockReg;
    doneNext    = doneReg;
    outBufNext  = outBufReg;
    idxInc      = outIdx + 2'd1;

    case (fsmState)
      IDLE, LOAD: begin
        if (bus.readFlag) begin
          if (!loadCnt[2]) begin
            keyNext[{~loadCnt[1:0], 5'b00000} +: 32] = bus.keyIn;
          end else begin
            blockNext[{~loadCnt[1:0], 5'b00000} +: 32] = bus.wordIn;
          end
          if (loadCnt == 3'd7) begin
            fsmNext     = RUN;
            loadCntNext = 3'd0;
            roundNext   = 4'd0;
          end else begin
            fsmNext     = LOAD;
            loadCntNext = loadCnt + 3'd1;
          end
        end
      end

      RUN: begin
        if (roundCnt == 4'd0) begin
          blockNext = blockReg ^ keyReg;
          roundNext = 4'd1;
        end else begin
          blockNext = roundOut;
          keyNext   = nextKey;
          if (roundCnt == 4'd10) begin
            fsmNext    = OUT;
            roundNext  = 4'd0;
            outIdxNext = 2'd0;
            doneNext   = 1'b1;
            outBufNext = roundOut[127:96];
          end else begin
            roundNext = roundCnt + 4'd1;
          end
        end
      end

      OUT: begin
        if (bus.writeFlag) begin
          if (outIdx == 2'd3) begin
            fsmNext    = IDLE;
            outIdxNext = 2'd0;
            doneNext   = 1'b0;
            outBufNext = 32'h0;
          end else begin
            outIdxNext = idxInc;
            outBufNext = blockReg[{~idxInc, 5'b00000} +: 32];
          end
        end
      end

      default: fsmNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes128_encrypt.sv
// Scoreboard bench for aes128_encrypt: directed FIPS-197 vectors, load gaps,
// unload stalls, resets in RUN/OUT and back-to-back blocks.
module tb_aes128_encrypt;

  logic Clk = 1'b0;
  logic rst;

  aes128_encrypt_if bus();

  aes128_encrypt dut (
    .Clk (Clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  localparam logic [127:0] KEY1 = 128'h0;
  localparam logic [127:0] PT1  = 128'h58c8e00b2631686d54eab84b91f0aca1;
  localparam logic [127:0] CT1  = 128'h08a4e2efec8a8e3312ca7460b9040bbf;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY3 = 128'h0;
  localparam logic [127:0] PT3  = 128'h0;
  localparam logic [127:0] CT3  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int          numChecks = 0;
  int          missCount = 0;
  logic [31:0] expectQ[$];
  logic [31:0] expWord;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every word presented while a pop strobe is high is compared
  // against the oldest expected ciphertext word.
  always @(negedge Clk) begin
    if (!rst && bus.done === 1'b1 && bus.writeFlag === 1'b1) begin
      if (expectQ.size() == 0) begin
        numChecks++;
        missCount++;
        $display("[TB] FAIL unexpectedPop: got %h, expected no word", bus.outBuf);
      end else begin
        expWord = expectQ.pop_front();
        checkOutput("ctWord", bus.outBuf, expWord);
      end
    end
  end

  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt,
                               input int gapBefore, input int gapLen,
                               input logic [127:0] ct, input bit doPush,
                               input int wordsToLoad);
    if (doPush) begin
      for (int w = 0; w < 4; w++) expectQ.push_back(ct[127 - 32*w -: 32]);
    end
    for (int k = 0; k < wordsToLoad; k++) begin
      if (k == gapBefore) begin
        repeat (gapLen) begin
          bus.readFlag = 1'b0;
          bus.keyIn    = $urandom;
          bus.wordIn   = $urandom;
          @(posedge Clk); #1;
        end
      end
      bus.readFlag = 1'b1;
      bus.keyIn    = (k < 4) ? key[127 - 32*k -: 32] : $urandom;
      bus.wordIn   = (k >= 4) ? pt[127 - 32*(k-4) -: 32] : $urandom;
      @(posedge Clk); #1;
    end
    bus.readFlag = 1'b0;
  endtask

  // Waits for done with stray load strobes in RUN; must rise on the 11th edge.
  task automatic waitDone();
    int n;
    n = 31;
    for (int i = 1; i <= 30; i++) begin
      bus.readFlag = i[0];
      bus.keyIn    = $urandom;
      bus.wordIn   = $urandom;
      @(posedge Clk); #1;
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
    end
    bus.readFlag = 1'b0;
    checkOutput("latency", n, 11);
  endtask

  task automatic unloadBlock(input int stall, input bit irregular);
    int gaps[4];
    gaps = '{1, 0, 3, 2};
    repeat (stall) begin
      @(posedge Clk); #1;
      checkOutput("doneStall", {31'b0, bus.done}, 32'd1);
    end
    for (int p = 0; p < 4; p++) begin
      if (irregular) begin
        repeat (gaps[p]) begin
          bus.readFlag = 1'b1;
          bus.keyIn    = $urandom;
          bus.wordIn   = $urandom;
          @(posedge Clk); #1;
          bus.readFlag = 1'b0;
          checkOutput("doneHold", {31'b0, bus.done}, 32'd1);
        end
      end
      bus.writeFlag = 1'b1;
      @(posedge Clk); #1;
      bus.writeFlag = 1'b0;
      if (p < 3) begin
        checkOutput("doneMid", {31'b0, bus.done}, 32'd1);
      end else begin
        checkOutput("doneFall", {31'b0, bus.done}, 32'd0);
        checkOutput("outBufClear", bus.outBuf, 32'h0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.keyIn     = 32'h0;
    bus.wordIn    = 32'h0;
    bus.readFlag  = 1'b0;
    bus.writeFlag = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    rst = 1'b0;
    checkOutput("resetDone", {31'b0, bus.done}, 32'd0);
    checkOutput("resetOutBuf", bus.outBuf, 32'h0);

    // Partial load discarded by reset.
    applyStimulus(KEY1, PT1, -1, 0, CT1, 1'b0, 3);
    rst = 1'b1;
    @(posedge Clk); #1;
    rst = 1'b0;

    // Abort mid-RUN with a two-cycle reset.
    applyStimulus(KEY1, PT1, -1, 0, CT1, 1'b0, 8);
    repeat (4) begin @(posedge Clk); #1; end
    rst = 1'b1;
    repeat (2) begin
      @(posedge Clk); #1;
      checkOutput("runRstDone", {31'b0, bus.done}, 32'd0);
      checkOutput("runRstOutBuf", bus.outBuf, 32'h0);
    end
    rst = 1'b0;

    // Appendix B vector, unloaded with a stall and irregular pops.
    applyStimulus(KEY2, PT2, -1, 0, CT2, 1'b1, 8);
    waitDone();
    unloadBlock(5, 1'b1);

    // Reset while ciphertext is on display.
    applyStimulus(KEY1, PT1, -1, 0, CT1, 1'b0, 8);
    waitDone();
    checkOutput("outWord0", bus.outBuf, 32'h08a4e2ef);
    rst = 1'b1;
    @(posedge Clk); #1;
    rst = 1'b0;
    checkOutput("outRstDone", {31'b0, bus.done}, 32'd0);
    checkOutput("outRstOutBuf", bus.outBuf, 32'h0);

    // Back-to-back blocks, the middle one with a load gap.
    applyStimulus(KEY1, PT1, -1, 0, CT1, 1'b1, 8);
    waitDone();
    unloadBlock(0, 1'b0);
    applyStimulus(KEY3, PT3, 3, 3, CT3, 1'b1, 8);
    waitDone();
    unloadBlock(0, 1'b0);
    applyStimulus(KEY2, PT2, -1, 0, CT2, 1'b1, 8);
    waitDone();
    unloadBlock(2, 1'b0);

    repeat (2) @(posedge Clk);
    #1;
    checkOutput("queueEmpty", expectQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, missCount);
    $finish;
  end

endmodule
